draw_scene_sequencer: RTL
=========================

# draw_scene_sequencer

Initiator for the background and gold/stone sprite draw FSMs. On a frame-start pulse it requests one full background redraw, then walks a fixed object table and requests one sprite draw per valid entry, holding each sprite origin stable while the drawer runs. It sits between the game-state logic, which owns the object table, and the three draw FSMs, and reports which drawer currently owns the framebuffer write port.

## Interface
- NUM_OBJ, 16, object table entries; IDX_W = clog2(NUM_OBJ)
- TIMEOUT_CYC, 262144, max cycles in any wait state before giving up on a drawer
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- frame_start  in  1  redraw request pulse
- obj_index  out  IDX_W  table address; table answers combinationally
- obj_valid / obj_is_gold  in  1 / 1  entry present / gold(1) or stone(0)
- obj_x / obj_y  in  9 / 8  entry origin
- sprite_x / sprite_y  out  9 / 8  latched origin driven to both sprite drawers
- enable_draw_background / enable_draw_gold / enable_draw_stone  out  1  one-cycle request pulses
- draw_background_done / draw_gold_done / draw_stone_done  in  1  drawer completion pulses
- draw_sel  out  2  write-port owner: 0 none, 1 background, 2 gold, 3 stone
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse at end of frame
- timeout_err  out  1  sticky; set on any wait timeout, cleared by accepted frame_start
- objects_drawn  out  IDX_W+1  sprites completed this frame

## Operation
- States: IDLE, BG_REQ, BG_WAIT, OBJ_FETCH, OBJ_REQ, OBJ_WAIT, FRAME_DONE.
- IDLE: frame_start=1 -> BG_REQ; clear timeout_err, objects_drawn, and index.
- BG_REQ: enable_draw_background=1, draw_sel=1 -> BG_WAIT.
- BG_WAIT: draw_sel=1; draw_background_done -> OBJ_FETCH; timeout -> set timeout_err, go to OBJ_FETCH.
- OBJ_FETCH: obj_index=index. If obj_valid, latch obj_x/obj_y into sprite_x/sprite_y, latch obj_is_gold, go to OBJ_REQ. Otherwise advance the index: go to FRAME_DONE if index==NUM_OBJ-1, else stay in OBJ_FETCH with index+1.
- OBJ_REQ: pulse enable_draw_gold or enable_draw_stone according to the latched type; draw_sel=2/3 -> OBJ_WAIT.
- OBJ_WAIT: draw_sel=2/3. A done from the matching drawer increments objects_drawn and advances the index, following the same last-entry rule as OBJ_FETCH. A done from a non-matching drawer is ignored. Timeout sets timeout_err and advances the index without incrementing objects_drawn.
- FRAME_DONE: frame_done=1, draw_sel=0 -> IDLE.
- frame_start outside IDLE is ignored and not queued.
- Done inputs are sampled only in the wait states. Done pulses arriving in any other state are ignored.
- The timeout counter clears on entry to every wait state and saturates at TIMEOUT_CYC-1. Timeout fires when the counter reaches TIMEOUT_CYC-1 without a done.
- sprite_x/sprite_y change only in OBJ_FETCH with a valid entry. They hold through the following OBJ_REQ/OBJ_WAIT, because the drawers reload the origin continuously while idle.

## Timing
- Reset values: state IDLE; all enables 0; draw_sel 0; busy 0; frame_done 0; timeout_err 0; objects_drawn 0; obj_index 0; sprite_x/sprite_y 0.
- Control outputs are Moore decodes of registered state. sprite_x, sprite_y, objects_drawn, and timeout_err are registers.
- Cycle sequence from frame_start sampled high at edge 0:
  - BG_REQ during cycle 1
  - BG_WAIT from cycle 2
  - done sampled at edge k -> OBJ_FETCH in cycle k+1
- Each invalid entry costs 1 cycle. Each valid entry costs 2 cycles plus the drawer's time to done.
- Minimum gap between a drawer's done and the next enable pulse is 2 cycles (FETCH, then REQ). This guarantees the drawer has returned to its load state before the next request.
- Reset asserted mid-frame aborts immediately to reset values. A drawer already in flight completes on its own; its done is ignored in IDLE.

## Structure
- Package draw_pkg holds:
  - draw_sel encodings (SEL_NONE/BG/GOLD/STONE)
  - the state localparams
  - coordinate widths X_W=9, Y_W=8
  - default NUM_OBJ and TIMEOUT_CYC
- One sub-module, draw_wait_timer: clear input, saturating counter, expired output. It is instantiated once and shared by both wait states.

## Test plan
- Empty table, background done 5 cycles after the request: enable_draw_background high exactly in cycle 1; frame_done in cycle k+17 for NUM_OBJ=16; objects_drawn=0; no sprite enables.
- Entry 3 = gold at (100,50), entry 7 = stone at (200,120), both drawers done after 20 cycles: one gold pulse, then one stone pulse; sprite_x/sprite_y stable across each wait; draw_sel sequence 1,2,3,0; objects_drawn=2.
- Gold drawer never answers, TIMEOUT_CYC=64: OBJ_WAIT exits after 64 cycles; timeout_err=1; frame still completes; the next frame_start clears timeout_err.
- frame_start pulsed during BG_WAIT, and draw_stone_done pulsed while the gold sprite is pending: both ignored, with no extra frame and no early advance.
- Reset raised in OBJ_WAIT for 1 cycle: all outputs return to reset values within the same cycle; a following frame_start runs a complete frame.
- Entry 15 valid only: request issued for index 15; FRAME_DONE follows the done with no index wrap to 0.

Source files
------------

// File: rtl/draw_pkg.sv
// Shared constants for the scene draw sequencer: write-port owner codes, FSM state codes,
// coordinate widths and default sizing.
package draw_pkg;

  localparam int unsigned X_W = 9;
  localparam int unsigned Y_W = 8;

  localparam int unsigned NUM_OBJ_DEF     = 16;
  localparam int unsigned TIMEOUT_CYC_DEF = 262144;

  localparam logic [1:0] SEL_NONE  = 2'd0;
  localparam logic [1:0] SEL_BG    = 2'd1;
  localparam logic [1:0] SEL_GOLD  = 2'd2;
  localparam logic [1:0] SEL_STONE = 2'd3;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_BG_REQ     = 3'd1;
  localparam logic [2:0] ST_BG_WAIT    = 3'd2;
  localparam logic [2:0] ST_OBJ_FETCH  = 3'd3;
  localparam logic [2:0] ST_OBJ_REQ    = 3'd4;
  localparam logic [2:0] ST_OBJ_WAIT   = 3'd5;
  localparam logic [2:0] ST_FRAME_DONE = 3'd6;

endpackage

// File: rtl/draw_wait_timer.sv
// Saturating wait counter shared by the background and sprite wait states; expired stays
// high once the counter reaches TIMEOUT_CYC-1 until the next clear.
module draw_wait_timer #(
  parameter int unsigned TIMEOUT_CYC = 262144
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = (cnt_q == CNT_MAX);

endmodule

// File: rtl/draw_scene_sequencer.sv
// Per-frame draw initiator: one background redraw, then one sprite request per valid object
// table entry, holding the sprite origin stable while the selected drawer runs.
module draw_scene_sequencer
  import draw_pkg::*;
#(
  parameter int unsigned NUM_OBJ     = NUM_OBJ_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       frame_start,
  output logic [$clog2(NUM_OBJ)-1:0] obj_index,
  input  logic                       obj_valid,
  input  logic                       obj_is_gold,
  input  logic [X_W-1:0]             obj_x,
  input  logic [Y_W-1:0]             obj_y,
  output logic [X_W-1:0]             sprite_x,
  output logic [Y_W-1:0]             sprite_y,
  output logic                       enable_draw_background,
  output logic                       enable_draw_gold,
  output logic                       enable_draw_stone,
  input  logic                       draw_background_done,
  input  logic                       draw_gold_done,
  input  logic                       draw_stone_done,
  output logic [1:0]                 draw_sel,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       timeout_err,
  output logic [$clog2(NUM_OBJ):0]   objects_drawn
);

  localparam int unsigned IDX_W = $clog2(NUM_OBJ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBJ - 1);

  logic [2:0]       state_q, state_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [X_W-1:0]   sprite_x_q, sprite_x_d;
  logic [Y_W-1:0]   sprite_y_q, sprite_y_d;
  logic             is_gold_q, is_gold_d;
  logic [IDX_W:0]   drawn_q, drawn_d;
  logic             err_q, err_d;

  logic timer_clear, timer_expired;
  logic match_done, advance;

  draw_wait_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .expired (timer_expired)
  );

  // Clearing in the request states means the counter reads 0 on the first wait cycle.
  assign timer_clear = (state_q == ST_BG_REQ) || (state_q == ST_OBJ_REQ);
  assign match_done  = is_gold_q ? draw_gold_done : draw_stone_done;

  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    sprite_x_d = sprite_x_q;
    sprite_y_d = sprite_y_q;
    is_gold_d  = is_gold_q;
    drawn_d    = drawn_q;
    err_d      = err_q;
    advance    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          state_d = ST_BG_REQ;
          err_d   = 1'b0;
          drawn_d = '0;
          index_d = '0;
        end
      end
      ST_BG_REQ: state_d = ST_BG_WAIT;
      ST_BG_WAIT: begin
        if (draw_background_done) begin
          state_d = ST_OBJ_FETCH;
        end else if (timer_expired) begin
          err_d   = 1'b1;
          state_d = ST_OBJ_FETCH;
        end
      end
      ST_OBJ_FETCH: begin
        if (obj_valid) begin
          sprite_x_d = obj_x;
          sprite_y_d = obj_y;
          is_gold_d  = obj_is_gold;
          state_d    = ST_OBJ_REQ;
        end else begin
          advance = 1'b1;
        end
      end
      ST_OBJ_REQ: state_d = ST_OBJ_WAIT;
      ST_OBJ_WAIT: begin
        // A done that coincides with expiry still counts as a completed sprite.
        if (match_done) begin
          drawn_d = drawn_q + 1'b1;
          advance = 1'b1;
        end else if (timer_expired) begin
          err_d   = 1'b1;
          advance = 1'b1;
        end
      end
      ST_FRAME_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (advance) begin
      if (index_q == LAST_IDX) begin
        state_d = ST_FRAME_DONE;
      end else begin
        index_d = index_q + 1'b1;
        state_d = ST_OBJ_FETCH;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      index_q    <= '0;
      sprite_x_q <= '0;
      sprite_y_q <= '0;
      is_gold_q  <= 1'b0;
      drawn_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      sprite_x_q <= sprite_x_d;
      sprite_y_q <= sprite_y_d;
      is_gold_q  <= is_gold_d;
      drawn_q    <= drawn_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    unique case (state_q)
      ST_BG_REQ, ST_BG_WAIT:   draw_sel = SEL_BG;
      ST_OBJ_REQ, ST_OBJ_WAIT: draw_sel = is_gold_q ? SEL_GOLD : SEL_STONE;
      default:                 draw_sel = SEL_NONE;
    endcase
  end

  assign enable_draw_background = (state_q == ST_BG_REQ);
  assign enable_draw_gold       = (state_q == ST_OBJ_REQ) && is_gold_q;
  assign enable_draw_stone      = (state_q == ST_OBJ_REQ) && !is_gold_q;
  assign busy                   = (state_q != ST_IDLE);
  assign frame_done             = (state_q == ST_FRAME_DONE);

  assign obj_index     = index_q;
  assign sprite_x      = sprite_x_q;
  assign sprite_y      = sprite_y_q;
  assign objects_drawn = drawn_q;
  assign timeout_err   = err_q;

endmodule
